// File: rtl/single_port_data_ram_pkg.sv
// Shared constants, types and helper functions for the data-memory stage.
package single_port_data_ram_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DMEM_DEPTH_DEF = 32;

    typedef logic [DATA_WIDTH_DEF-1:0] data_word_t;

    // Smallest w with 2**w >= n; used to size the word index.
    function automatic int unsigned dmem_clog2(input int unsigned n);
        int unsigned w;
        w = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((33'd1 << i) < {1'b0, n}) begin
                w = 32'(i) + 32'd1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/single_port_data_ram_if.sv
// Single-port data memory bus: shared address, write enable, write data and read data.
interface single_port_data_ram_if
    import single_port_data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] q;

    modport master (output we, output addr, output data, input  q);
    modport slave  (input  we, input  addr, input  data, output q);
endinterface

// File: rtl/single_port_data_ram.sv
// Word-addressed single-port data RAM: synchronous write, registered read
// address, write-first, with an asynchronous clear of the whole array.
module single_port_data_ram
    import single_port_data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int MEMORY_DEPTH = DMEM_DEPTH_DEF
) (
    input logic                   clk,
    input logic                   reset,
    single_port_data_ram_if.slave bus
);

    localparam int IDX_W = int'(dmem_clog2(MEMORY_DEPTH));
    // Depth widened by one bit so the range compare stays exact even when
    // MEMORY_DEPTH equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];
    logic [IDX_W-1:0]      r_addr_q;
    logic                  r_addr_ok;

    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_q;

    // Upper address bits only feed the range check; they never alias onto a word.
    assign w_in_range = ({1'b0, bus.addr} < DEPTH_EXT);
    assign w_idx      = bus.addr[IDX_W-1:0];

    // Storage array: cleared on reset, written only for in-range addresses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEMORY_DEPTH; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (bus.we && w_in_range) begin
            r_mem[w_idx] <= bus.data;
        end
    end

    // Read address register and its range flag, captured every edge regardless of we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_q  <= {IDX_W{1'b0}};
            r_addr_ok <= 1'b1;
        end else begin
            r_addr_q  <= w_idx;
            r_addr_ok <= w_in_range;
        end
    end

    // Read mux from the registered address; write-first falls out because the
    // array and the address register update on the same edge.
    always_comb begin
        w_q = {DATA_WIDTH{1'b0}};
        if (r_addr_ok) begin
            w_q = r_mem[r_addr_q];
        end else begin
            w_q = {DATA_WIDTH{1'b0}};
        end
    end

    assign bus.q = w_q;

endmodule

// File: tb/tb_single_port_data_ram.sv
// Directed bench for single_port_data_ram with a behavioural memory model.
module tb_single_port_data_ram;
    import single_port_data_ram_pkg::*;

    localparam int DEPTH = 32;

    logic clk;
    logic reset;

    single_port_data_ram_if bus_if ();

    single_port_data_ram #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEMORY_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: words ever written at an in-range address, keyed by full address,
    // plus the address presented at the last rising edge.
    data_word_t  mdl_mem [logic [31:0]];
    logic [31:0] mdl_last_addr;

    int         checks;
    int         errors;
    logic       cmp_en;
    logic       lit_en;
    data_word_t lit_val;
    string      lit_name;

    function automatic data_word_t model_q();
        if (mdl_last_addr < 32'(DEPTH) && mdl_mem.exists(mdl_last_addr)) begin
            return mdl_mem[mdl_last_addr];
        end
        return 32'h0000_0000;
    endfunction

    // Single compare process: model check every cycle plus any pinned literal.
    initial begin
        checks = 0;
        errors = 0;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                checks++;
                if (bus_if.q !== model_q()) begin
                    errors++;
                    $display("FAIL model_cmp t=%0t addr_prev=%h: q=%h expected %h",
                             $time, mdl_last_addr, bus_if.q, model_q());
                end
                if (lit_en) begin
                    checks++;
                    if (bus_if.q !== lit_val) begin
                        errors++;
                        $display("FAIL %s: q=%h expected %h", lit_name, bus_if.q, lit_val);
                    end
                end
            end
        end
    end

    // One clock of stimulus; called at posedge+2, returns at posedge+2.
    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic has_lit, input logic [31:0] lit, input string nm);
        bus_if.we   = w;
        bus_if.addr = a;
        bus_if.data = d;
        @(posedge clk);
        if (w && a < 32'(DEPTH)) mdl_mem[a] = d;
        mdl_last_addr = a;
        #2;
        lit_en   = has_lit;
        lit_val  = lit;
        lit_name = nm;
    endtask

    initial begin
        reset         = 1'b1;
        bus_if.we     = 1'b0;
        bus_if.addr   = 32'h0;
        bus_if.data   = 32'h0;
        cmp_en        = 1'b0;
        lit_en        = 1'b0;
        lit_val       = 32'h0;
        lit_name      = "none";
        mdl_last_addr = 32'h0;
        mdl_mem.delete();

        // Reset applied and released with no clock edge in between.
        #3;
        reset    = 1'b0;
        cmp_en   = 1'b1;
        lit_en   = 1'b1;
        lit_val  = 32'h0;
        lit_name = "reset_q";
        @(negedge clk);
        #1;
        lit_en = 1'b0;
        @(posedge clk);
        #2;

        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 32'(i), 32'h0, 1'b1, 32'h0, "reset_read");
        end

        // Write then read back.
        step(1'b1, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, "wr0");
        step(1'b1, 32'd2, 32'h1234_5678, 1'b1, 32'h1234_5678, "wr2");
        step(1'b1, 32'd3, 32'h9876_1234, 1'b1, 32'h9876_1234, "wr3");
        step(1'b1, 32'd4, 32'hA0A0_A0A0, 1'b1, 32'hA0A0_A0A0, "wr4");
        step(1'b1, 32'd5, 32'hABCD_EF12, 1'b1, 32'hABCD_EF12, "wr5");
        step(1'b0, 32'd0, 32'h0, 1'b1, 32'hFFFF_FFFF, "rd0");
        step(1'b0, 32'd1, 32'h0, 1'b1, 32'h0000_0000, "rd1");
        step(1'b0, 32'd2, 32'h0, 1'b1, 32'h1234_5678, "rd2");
        step(1'b0, 32'd3, 32'h0, 1'b1, 32'h9876_1234, "rd3");
        step(1'b0, 32'd4, 32'h0, 1'b1, 32'hA0A0_A0A0, "rd4");
        step(1'b0, 32'd5, 32'h0, 1'b1, 32'hABCD_EF12, "rd5");

        // Write-first on one address, back-to-back.
        step(1'b1, 32'd7, 32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE, "wf1");
        step(1'b1, 32'd7, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, "wf2");

        // Out of range: no aliasing onto word 0.
        step(1'b1, 32'd32, 32'hDEAD_BEEF, 1'b1, 32'h0, "oor_wr");
        step(1'b0, 32'd0, 32'h0, 1'b1, 32'hFFFF_FFFF, "oor_word0");
        step(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0, "oor_hi");
        step(1'b0, 32'd31, 32'h0, 1'b1, 32'h0, "top_word");
        step(1'b1, 32'd31, 32'h5A5A_0001, 1'b1, 32'h5A5A_0001, "top_wr");

        // we low holds memory contents.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd2, 32'h1111_1111, 1'b1, 32'h1234_5678, "we_low");
        end

        // Asynchronous reset between edges.
        step(1'b0, 32'd4, 32'h0, 1'b1, 32'hA0A0_A0A0, "pre_rst");
        reset         = 1'b1;
        mdl_mem.delete();
        mdl_last_addr = 32'h0;
        lit_en        = 1'b1;
        lit_val       = 32'h0;
        lit_name      = "async_rst";
        @(posedge clk);
        #2;
        reset = 1'b0;
        step(1'b0, 32'd4, 32'h0, 1'b1, 32'h0, "post_rst4");
        step(1'b0, 32'd7, 32'h0, 1'b1, 32'h0, "post_rst7");

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
